rom: RTL and testbench

- 256-word x 32-bit microcode store for the microcoded decoder.
- The decoder forms an 8-bit microcode address from the FSM phase and opcode:
  - fetch words at fixed addresses;
  - decode page 0-63 (opcode);
  - read page 64-127 (opcode+64);
  - exec page 128-191 (opcode+128).
- The block returns the 32-bit control word that drives the load strobes, mux selects and immediate select.
- Contents are fixed at elaboration. There is no write port.

---
 rtl/microcode_pkg.sv | 110 +++++++++++
 rtl/rom.sv | 47 ++++
 tb/tb_rom.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/microcode_pkg.sv
// -----------------------------------------------------------------------------
// microcode_pkg
// Shared definitions for the microcoded decoder and its microcode store (rom).
// The package holds:
//   - bit positions of every control-word field;
//   - register-select and immediate-select encodings;
//   - microcode page bases and the fixed fetch/NOP addresses;
//   - make_cword(), which assembles a control word from named fields;
//   - ROM_TABLE, the 256-entry microcode contents.
// New microcode is added in build_rom(). Any address left unset reads as zero,
// which is a NOP because every strobe is deasserted.
// -----------------------------------------------------------------------------
package microcode_pkg;

  localparam int ROM_DEPTH = 256;
  localparam int CW_W      = 32;

  typedef logic [CW_W-1:0] cword_t;
  typedef logic [ROM_DEPTH-1:0][CW_W-1:0] rom_table_t;

  // Control-word field positions (single bits, or LSB of a multi-bit field).
  localparam int MAR_LOAD_BIT = 31;
  localparam int IR_LOAD_BIT  = 30;
  localparam int MDR_LOAD_BIT = 29;
  localparam int REG_LOAD_BIT = 28;
  localparam int RAM_LOAD_BIT = 27;
  localparam int INCR_PC_BIT  = 26;  // reserved, stored 0
  localparam int SKIP_BIT     = 25;  // reserved, stored 0
  localparam int BE_BIT       = 24;
  localparam int REGR0S_LSB   = 20;  // [23:20]
  localparam int REGR1S_LSB   = 16;  // [19:16]
  localparam int REGWS_LSB    = 12;  // [15:12]
  localparam int MDRS_LSB     = 10;  // [11:10]
  localparam int IMMS_LSB     = 7;   // [9:7]
  localparam int OP0S_LSB     = 5;   // [6:5]
  localparam int OP1S_LSB     = 3;   // [4:3]

  // Register-select encodings. Codes 0-7 name a literal register.
  localparam logic [3:0] RS_PC   = 4'd7;
  localparam logic [3:0] RS_ARG0 = 4'd8;
  localparam logic [3:0] RS_ARG1 = 4'd9;
  localparam logic [3:0] RS_TGT  = 4'd10;
  localparam logic [3:0] RS_TGT2 = 4'd11;

  // Immediate-select encodings. Any other code selects no immediate.
  localparam logic [2:0] IMM7     = 3'd0;
  localparam logic [2:0] IMM10    = 3'd1;
  localparam logic [2:0] IMM13    = 3'd2;
  localparam logic [2:0] IMM_NONE = 3'd3;

  // Microcode page bases, each indexed by opcode, plus the fixed addresses.
  localparam logic [7:0] DECODE_BASE = 8'd0;
  localparam logic [7:0] READ_BASE   = 8'd64;
  localparam logic [7:0] EXEC_BASE   = 8'd128;
  localparam logic [7:0] FETCH_ADDR  = 8'd2;
  localparam logic [7:0] NOP_ADDR    = 8'd3;

  // Assemble a control word from named fields. The reserved bits
  // (INCR_PC, SKIP and [2:0]) are always left at zero.
  function automatic cword_t make_cword(
    input logic       mar_load,
    input logic       ir_load,
    input logic       mdr_load,
    input logic       reg_load,
    input logic       ram_load,
    input logic       be,
    input logic [3:0] regr0s,
    input logic [3:0] regr1s,
    input logic [3:0] regws,
    input logic [1:0] mdrs,
    input logic [2:0] imms,
    input logic [1:0] op0s,
    input logic [1:0] op1s
  );
    cword_t w;
    w                    = '0;
    w[MAR_LOAD_BIT]      = mar_load;
    w[IR_LOAD_BIT]       = ir_load;
    w[MDR_LOAD_BIT]      = mdr_load;
    w[REG_LOAD_BIT]      = reg_load;
    w[RAM_LOAD_BIT]      = ram_load;
    w[BE_BIT]            = be;
    w[REGR0S_LSB +: 4]   = regr0s;
    w[REGR1S_LSB +: 4]   = regr1s;
    w[REGWS_LSB +: 4]    = regws;
    w[MDRS_LSB +: 2]     = mdrs;
    w[IMMS_LSB +: 3]     = imms;
    w[OP0S_LSB +: 2]     = op0s;
    w[OP1S_LSB +: 2]     = op1s;
    return w;
  endfunction

  // Microcode contents. Everything not set explicitly is zero (NOP).
  // Addresses 192-255 are unused and must stay zero.
  function automatic rom_table_t build_rom();
    rom_table_t t;
    t = '0;
    // Fetch: address the PC, load MAR and IR.
    t[FETCH_ADDR] = make_cword(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               RS_PC, 4'd0, 4'd0, 2'd0, IMM7, 2'd0, 2'd0);
    // NOP_ADDR stays all-zero.
    // Exec, opcode 0: write the target register using a 7-bit immediate.
    t[EXEC_BASE + 8'd0] = make_cword(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                     4'd0, 4'd0, RS_TGT, 2'd0, IMM7, 2'd0, 2'd0);
    return t;
  endfunction

  localparam rom_table_t ROM_TABLE = build_rom();

endpackage

// File: rtl/rom.sv
// -----------------------------------------------------------------------------
// rom
// 256 x 32 microcode store with a registered output. Contents come from
// microcode_pkg::ROM_TABLE and are fixed at elaboration; there is no write port.
//
// Ports:
//   clk      in   system clock; the output register updates on the rising edge
//   reset    in   asynchronous, active-low; clears data to 0 (a NOP word)
//   address  in   [ADDR_W-1:0] microcode address
//   data     out  [DATA_W-1:0] registered control word, MEM[address] one
//                 rising edge later
//
// The decoder changes address on the falling edge. The word is therefore
// valid by the next falling edge.
// -----------------------------------------------------------------------------
module rom
  import microcode_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Every address in the table is defined, so the lookup never yields X.
  always_comb begin
    data_d = DATA_W'(ROM_TABLE[address]);
  end

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_rom.sv
// -----------------------------------------------------------------------------
// tb_rom
// Self-checking bench for rom. The reference is a microcode map taken from
// the documented contents: fetch at 2, exec opcode 0 at 128, zero elsewhere.
// It is paired with an expected-output register that follows the one-cycle
// read and the asynchronous clear. A compare process checks the DUT on every
// falling edge. Directed steps pin the model with literal words and field
// values, and a randomized phase drives addresses and reset pulses.
// -----------------------------------------------------------------------------
module tb_rom;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [31:0] data;

  int compared   = 0;
  int mismatched = 0;

  logic        chk_en = 1'b0;
  logic [31:0] exp_q  = 32'h0;

  rom #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data)
  );

  always #5 clk = ~clk;

  // Microcode contents as documented.
  function automatic logic [31:0] ref_word(input int a);
    if (a == 2)   return 32'hC070_0000;
    if (a == 128) return 32'h1000_A000;
    return 32'h0000_0000;
  endfunction

  // Expected output: cleared while reset is low, and otherwise the word of the
  // address seen at the rising edge.
  always @(posedge clk or negedge reset) begin
    if (reset !== 1'b1) exp_q <= 32'h0;
    else                exp_q <= ref_word(int'(address));
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Continuous check against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) check("model", data, exp_q);
  end

  task automatic drive_addr(input logic [7:0] a);
    @(negedge clk);
    address = a;
  endtask

  initial begin
    reset   = 1'b1;
    address = 8'd2;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;

    // Held in reset: clock edges must not load anything.
    repeat (3) @(posedge clk);
    #1 check("reset_hold", data, 32'h0);

    // Release reset at a falling edge. The first rising edge loads fetch.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("fetch_word", data, 32'hC070_0000);
    check("fetch_mar",  {31'h0, data[31]}, 32'h1);
    check("fetch_ir",   {31'h0, data[30]}, 32'h1);
    check("fetch_r0s",  {28'h0, data[23:20]}, 32'h7);

    // Latency: each word appears exactly one rising edge after its address.
    drive_addr(8'd2);
    drive_addr(8'd3);
    check("lat_2", data, 32'hC070_0000);
    drive_addr(8'd128);
    check("lat_3", data, 32'h0000_0000);
    @(negedge clk);
    check("lat_128", data, 32'h1000_A000);
    check("exec_regld", {31'h0, data[28]}, 32'h1);
    check("exec_regws", {28'h0, data[15:12]}, 32'd10);
    check("exec_imms",  {29'h0, data[9:7]}, 32'd0);

    // Reset asserted mid-cycle clears the output without a clock edge.
    drive_addr(8'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_clear", data, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Unused region reads zero.
    for (int a = 192; a < 256; a++) begin
      drive_addr(8'(a));
      @(posedge clk);
      #1 check("unused", data, 32'h0);
    end

    // Reserved bits are zero for every address.
    for (int a = 0; a < 256; a++) begin
      drive_addr(8'(a));
      @(posedge clk);
      #1;
      check("rsv_26_25", {30'h0, data[26:25]}, 32'h0);
      check("rsv_2_0",   {29'h0, data[2:0]},   32'h0);
    end

    // Hold: a mid-cycle address change must not reach data before the edge.
    drive_addr(8'd2);
    repeat (5) @(posedge clk);
    #1 check("hold_5", data, 32'hC070_0000);
    #2 address = 8'd128;
    #1 check("hold_mid", data, 32'hC070_0000);
    @(negedge clk);
    check("hold_neg", data, 32'hC070_0000);
    @(posedge clk);
    #1 check("hold_next", data, 32'h1000_A000);

    // Randomized addresses with occasional mid-cycle reset pulses.
    for (int i = 0; i < 2000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      @(negedge clk);
      case (sel)
        0: address = 8'd2;
        1: address = 8'd128;
        2: address = 8'd3;
        default: address = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 49) == 0) begin
        #3 reset = 1'b0;
        #1 check("rand_rst", data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
